// File: rtl/qtree_heap_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// qtree_heap_write_arbiter_pkg
// Types and defaults shared by the QTree heap write arbiter and its users.
//   qtree_ptr_t  : heap pointer {addr, valid}, valid in bit 0
//   qtree_node_t : heap node word {payload, valid}, valid in bit 0
//   ptr_dc()     : builds a valid pointer from an address
//   node_dc()    : builds a valid node word from a payload
// No ports (package).
// -----------------------------------------------------------------------------
package qtree_heap_write_arbiter_pkg;

  localparam int QT_NUM_REQ = 4;
  localparam int QT_DATA_W  = 67;
  localparam int QT_ADDR_W  = 16;
  localparam int QT_DEPTH   = 256;
  localparam int QT_STAT_W  = 16;

  typedef struct packed {
    logic [QT_ADDR_W-1:0] addr;
    logic                 valid;
  } qtree_ptr_t;

  typedef struct packed {
    logic [QT_DATA_W-2:0] payload;
    logic                 valid;
  } qtree_node_t;

  function automatic qtree_ptr_t ptr_dc(input logic [QT_ADDR_W-1:0] addr);
    qtree_ptr_t p;
    p.addr  = addr;
    p.valid = 1'b1;
    return p;
  endfunction

  function automatic qtree_node_t node_dc(input logic [QT_DATA_W-2:0] payload);
    qtree_node_t n;
    n.payload = payload;
    n.valid   = 1'b1;
    return n;
  endfunction

endpackage

// File: rtl/qtree_heap_write_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// qtree_heap_write_arbiter_rr_arbiter
// Purely combinational round-robin picker: the first eligible index at or
// after rr_ptr_i (modulo NUM_REQ) wins.
//   eligible_i  in  NUM_REQ  requesters allowed to win this cycle
//   rr_ptr_i    in  PTR_W    index with highest priority this cycle
//   grant_o     out NUM_REQ  one-hot grant (all zero when nobody eligible)
//   grant_idx_o out PTR_W    binary index of the winner
//   grant_vld_o out 1        a grant was issued
// -----------------------------------------------------------------------------
module qtree_heap_write_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   grant_idx_o,
  output logic               grant_vld_o
);

  int unsigned idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    idx         = 0;
    // Walk the ring starting at rr_ptr_i; the first hit wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_i) + k) % NUM_REQ;
      if (!grant_vld_o && eligible_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = PTR_W'(idx);
        grant_vld_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qtree_heap_write_arbiter.sv
// -----------------------------------------------------------------------------
// qtree_heap_write_arbiter
// Shares the single QTree heap write port between NUM_REQ allocator channels.
// One write per cycle, round-robin; the heap address is bump-allocated and a
// {addr,valid} pointer is returned to the granted requester one cycle later.
//
// Handshake: req_r[i] is combinational and equals the grant; a word moves when
// req_d[i][0] & req_r[i]. Each requester holds one outstanding pointer on
// rsp_d[i]; it retires on a cycle where rsp_r[i]=1, and a new grant to i in
// that same cycle reloads the slot with no bubble.
//
// Ports:
//   clk, aresetn   clock (rising) and async active-low reset
//   req_d/req_r    per-requester node words (bit0 valid) / accepts
//   rsp_d/rsp_r    per-requester pointers {addr,valid} / consume
//   heap_we/heap_addr/heap_wdata  registered heap write port
//   soft_clear     rewinds the allocator; honoured only when fully idle
//   heap_full      allocator reached DEPTH; no grants while set
// Optional (macro ARB_STATS_EN):
//   grant_cnt      NUM_REQ x 16 saturating per-requester grant counters
//   stall_cnt      16-bit saturating count of cycles with a valid req but no grant
// -----------------------------------------------------------------------------
module qtree_heap_write_arbiter
  import qtree_heap_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = QT_NUM_REQ,
  parameter int DATA_W  = QT_DATA_W,
  parameter int ADDR_W  = QT_ADDR_W,
  parameter int DEPTH   = QT_DEPTH
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [NUM_REQ*DATA_W-1:0]     req_d,
  output logic [NUM_REQ-1:0]            req_r,
  output logic [NUM_REQ*(ADDR_W+1)-1:0] rsp_d,
  input  logic [NUM_REQ-1:0]            rsp_r,
  output logic                          heap_we,
  output logic [ADDR_W-1:0]             heap_addr,
  output logic [DATA_W-1:0]             heap_wdata,
  input  logic                          soft_clear,
  output logic                          heap_full
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = ADDR_W + 1;  // must be able to hold DEPTH itself

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   alloc_q, alloc_d;
  logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [ADDR_W-1:0]  rsp_addr_q [NUM_REQ];
  logic [ADDR_W-1:0]  rsp_addr_d [NUM_REQ];
  logic               heap_we_q, heap_we_d;
  logic [ADDR_W-1:0]  heap_addr_q, heap_addr_d;
  logic [DATA_W-1:0]  heap_wdata_q, heap_wdata_d;

  logic [NUM_REQ-1:0] req_vld, eligible, grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic               full;
  logic               clear_ok;

  assign full     = (alloc_q == CNT_W'(DEPTH));
  assign clear_ok = soft_clear && !(|req_vld) && !(|rsp_vld_q);

  // A slot being consumed this cycle counts as free, giving back-to-back reloads.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vld[i]  = req_d[i*DATA_W];
      eligible[i] = req_vld[i] && (!rsp_vld_q[i] || rsp_r[i]) && !full;
    end
  end

  qtree_heap_write_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .eligible_i  (eligible),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (gnt_idx),
    .grant_vld_o (gnt_vld)
  );

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    alloc_d      = alloc_q;
    rsp_vld_d    = rsp_vld_q;
    rsp_addr_d   = rsp_addr_q;
    heap_we_d    = gnt_vld;
    heap_addr_d  = heap_addr_q;
    heap_wdata_d = heap_wdata_q;

    if (gnt_vld) begin
      heap_addr_d = alloc_q[ADDR_W-1:0];
      alloc_d     = alloc_q + CNT_W'(1);
      rr_ptr_d    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        heap_wdata_d  = req_d[i*DATA_W +: DATA_W];
        rsp_vld_d[i]  = 1'b1;
        rsp_addr_d[i] = alloc_q[ADDR_W-1:0];
      end else if (rsp_r[i]) begin
        rsp_vld_d[i]  = 1'b0;
      end
    end

    // clear_ok implies no valid request, so it never races a grant.
    if (clear_ok) alloc_d = '0;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_q     <= '0;
      alloc_q      <= '0;
      rsp_vld_q    <= '0;
      heap_we_q    <= 1'b0;
      heap_addr_q  <= '0;
      heap_wdata_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) rsp_addr_q[i] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      alloc_q      <= alloc_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_addr_q   <= rsp_addr_d;
      heap_we_q    <= heap_we_d;
      heap_addr_q  <= heap_addr_d;
      heap_wdata_q <= heap_wdata_d;
    end
  end

  assign req_r      = grant;
  assign heap_we    = heap_we_q;
  assign heap_addr  = heap_addr_q;
  assign heap_wdata = heap_wdata_q;
  assign heap_full  = full;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_d[i*(ADDR_W+1) +: (ADDR_W+1)] = {rsp_addr_q[i], rsp_vld_q[i]};
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] gcnt_q [NUM_REQ];
  logic [15:0] gcnt_d [NUM_REQ];
  logic [15:0] stall_q, stall_d;

  always_comb begin
    gcnt_d  = gcnt_q;
    stall_d = stall_q;
    if (clear_ok) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt_d[i] = '0;
      stall_d = '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && gcnt_q[i] != 16'hFFFF) gcnt_d[i] = gcnt_q[i] + 16'd1;
      end
      if ((|req_vld) && !gnt_vld && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
      stall_q <= '0;
    end else begin
      gcnt_q  <= gcnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = gcnt_q[i];
  end
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_qtree_heap_write_arbiter.sv
module tb_qtree_heap_write_arbiter;
  import qtree_heap_write_arbiter_pkg::*;

  localparam int NR  = 4;
  localparam int DW  = 67;
  localparam int AW  = 16;
  localparam int DEP = 8;
  localparam int PW  = AW + 1;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NR*DW-1:0]  req_d = '0;
  logic [NR-1:0]     req_r;
  logic [NR*PW-1:0]  rsp_d;
  logic [NR-1:0]     rsp_r = '0;
  logic              heap_we;
  logic [AW-1:0]     heap_addr;
  logic [DW-1:0]     heap_wdata;
  logic              soft_clear = 1'b0;
  logic              heap_full;
`ifdef ARB_STATS_EN
  logic [NR*16-1:0]  grant_cnt;
  logic [15:0]       stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  qtree_heap_write_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .DEPTH   (DEP)
  ) u_dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .req_d      (req_d),
    .req_r      (req_r),
    .rsp_d      (rsp_d),
    .rsp_r      (rsp_r),
    .heap_we    (heap_we),
    .heap_addr  (heap_addr),
    .heap_wdata (heap_wdata),
    .soft_clear (soft_clear),
    .heap_full  (heap_full)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn    = 1'b0;
    req_d      = '0;
    rsp_r      = '0;
    soft_clear = 1'b0;
    tick();
    aresetn = 1'b1;
  endtask

  // ---------------- drivers / helpers ----------------
  function automatic logic [DW-1:0] word(input int r, input int k);
    return node_dc(66'(32'hA000 + r * 256 + k));
  endfunction

  task automatic set_req(input int r, input logic [DW-1:0] w);
    req_d[r*DW +: DW] = w;
  endtask

  function automatic logic [PW-1:0] rsp_of(input int r);
    return rsp_d[r*PW +: PW];
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    #2;
    n_checks++; if (heap_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", heap_we); end
    n_checks++; if (heap_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", heap_addr); end
    n_checks++; if (heap_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", heap_wdata); end
    n_checks++; if (heap_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", heap_full); end
    n_checks++; if (rsp_d !== '0) begin n_fail++; $display("FAIL reset_rsp got %h want 0", rsp_d); end
    n_checks++; if (req_r !== '0) begin n_fail++; $display("FAIL reset_req_r got %b want 0", req_r); end
    tick();
    aresetn = 1'b1;
  endtask

  // Requester 0 streams A,B,C back to back while consuming its pointers.
  task automatic test_single();
    do_reset();
    rsp_r = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      set_req(0, word(0, k));
      #1;
      n_checks++; if (req_r !== 4'b0001) begin n_fail++; $display("FAIL single_req_r%0d got %b want 0001", k, req_r); end
      tick();
      n_checks++; if (heap_we !== 1'b1) begin n_fail++; $display("FAIL single_we%0d got %b want 1", k, heap_we); end
      n_checks++; if (heap_addr !== AW'(k)) begin n_fail++; $display("FAIL single_addr%0d got %0d want %0d", k, heap_addr, k); end
      n_checks++; if (heap_wdata !== word(0, k)) begin n_fail++; $display("FAIL single_wdata%0d got %h want %h", k, heap_wdata, word(0, k)); end
      n_checks++; if (rsp_of(0) !== ptr_dc(AW'(k))) begin n_fail++; $display("FAIL single_rsp%0d got %h want %h", k, rsp_of(0), ptr_dc(AW'(k))); end
    end
    req_d = '0;
    tick();
    n_checks++; if (heap_we !== 1'b0) begin n_fail++; $display("FAIL single_idle_we got %b want 0", heap_we); end
    n_checks++; if (rsp_of(0) !== {AW'(2), 1'b0}) begin n_fail++; $display("FAIL single_rsp_retire got %h want %h", rsp_of(0), {AW'(2), 1'b0}); end
  endtask

  // All four valid: 0,1,2,3,0,1,2,3 fills the 8-entry heap, then full/stall/clear.
  task automatic test_round_robin_full();
    int g;
    do_reset();
    rsp_r = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < NR; r++) set_req(r, word(r, k));
      g = k % NR;
      #1;
      n_checks++; if (req_r !== 4'(1 << g)) begin n_fail++; $display("FAIL rr_req_r%0d got %b want %b", k, req_r, 4'(1 << g)); end
      tick();
      n_checks++; if (heap_addr !== AW'(k)) begin n_fail++; $display("FAIL rr_addr%0d got %0d want %0d", k, heap_addr, k); end
      n_checks++; if (heap_wdata !== word(g, k)) begin n_fail++; $display("FAIL rr_wdata%0d got %h want %h", k, heap_wdata, word(g, k)); end
      n_checks++; if (rsp_of(g) !== ptr_dc(AW'(k))) begin n_fail++; $display("FAIL rr_rsp%0d got %h want %h", k, rsp_of(g), ptr_dc(AW'(k))); end
    end
    #1;
    n_checks++; if (heap_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b want 1", heap_full); end
    n_checks++; if (req_r !== 4'b0000) begin n_fail++; $display("FAIL full_req_r got %b want 0000", req_r); end
    tick();
    n_checks++; if (heap_we !== 1'b0) begin n_fail++; $display("FAIL full_we got %b want 0", heap_we); end
    // soft_clear with requests still valid must be ignored
    soft_clear = 1'b1;
    tick();
    soft_clear = 1'b0;
    n_checks++; if (heap_full !== 1'b1) begin n_fail++; $display("FAIL clear_ignored got full=%b want 1", heap_full); end
    req_d = '0;
    tick();
    soft_clear = 1'b1;
    tick();
    soft_clear = 1'b0;
    n_checks++; if (heap_full !== 1'b0) begin n_fail++; $display("FAIL clear_full got %b want 0", heap_full); end
    set_req(2, word(2, 9));
    #1;
    n_checks++; if (req_r !== 4'b0100) begin n_fail++; $display("FAIL clear_req_r got %b want 0100", req_r); end
    tick();
    n_checks++; if (heap_addr !== AW'(0) || heap_we !== 1'b1) begin n_fail++; $display("FAIL clear_addr got we=%b addr=%0d want we=1 addr=0", heap_we, heap_addr); end
    req_d = '0;
  endtask

  // Requester 1 never consumes: granted once, then skipped; its pointer holds.
  task automatic test_hold();
    int exp_g [8];
    exp_g = '{0, 1, 2, 3, 0, 2, 3, 0};
    do_reset();
    rsp_r = 4'b1101;
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < NR; r++) set_req(r, word(r, k));
      #1;
      n_checks++; if (req_r !== 4'(1 << exp_g[k])) begin n_fail++; $display("FAIL hold_req_r%0d got %b want %b", k, req_r, 4'(1 << exp_g[k])); end
      tick();
      n_checks++; if (heap_addr !== AW'(k)) begin n_fail++; $display("FAIL hold_addr%0d got %0d want %0d", k, heap_addr, k); end
      if (k >= 1) begin
        n_checks++; if (rsp_of(1) !== ptr_dc(AW'(1))) begin n_fail++; $display("FAIL hold_rsp1_%0d got %h want %h", k, rsp_of(1), ptr_dc(AW'(1))); end
      end
    end
    tick();
    n_checks++; if (heap_full !== 1'b1 || rsp_of(1) !== ptr_dc(AW'(1))) begin n_fail++; $display("FAIL hold_full_rsp got full=%b rsp=%h want full=1 rsp=%h", heap_full, rsp_of(1), ptr_dc(AW'(1))); end
    rsp_r = 4'b1111;
    tick();
    n_checks++; if (rsp_of(1) !== {AW'(1), 1'b0}) begin n_fail++; $display("FAIL hold_retire got %h want %h", rsp_of(1), {AW'(1), 1'b0}); end
    req_d = '0;
  endtask

  // Reset right after a grant drops the write and the pointers.
  task automatic test_reset_mid();
    do_reset();
    rsp_r = 4'b1111;
    set_req(2, word(2, 0));
    tick();
    n_checks++; if (heap_we !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_we got %b want 1", heap_we); end
    aresetn = 1'b0;
    #1;
    n_checks++; if (heap_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we got %b want 0", heap_we); end
    n_checks++; if (rsp_d !== '0) begin n_fail++; $display("FAIL rmid_rsp got %h want 0", rsp_d); end
    req_d = '0;
    tick();
    aresetn = 1'b1;
    for (int r = 0; r < NR; r++) set_req(r, word(r, 1));
    #1;
    n_checks++; if (req_r !== 4'b0001) begin n_fail++; $display("FAIL rmid_req_r got %b want 0001", req_r); end
    tick();
    n_checks++; if (heap_addr !== AW'(0) || heap_wdata !== word(0, 1)) begin n_fail++; $display("FAIL rmid_first got addr=%0d data=%h want addr=0 data=%h", heap_addr, heap_wdata, word(0, 1)); end
    n_checks++; if (rsp_of(0) !== ptr_dc(AW'(0))) begin n_fail++; $display("FAIL rmid_rsp0 got %h want %h", rsp_of(0), ptr_dc(AW'(0))); end
    req_d = '0;
  endtask

`ifdef ARB_STATS_EN
  // 3 grants to req2, 5 to req0 (fills heap), then 5 full-stall cycles.
  task automatic test_stats();
    do_reset();
    rsp_r = 4'b1111;
    set_req(2, word(2, 0));
    repeat (3) tick();
    req_d = '0;
    set_req(0, word(0, 0));
    repeat (5) tick();
    req_d = '0;
    set_req(2, word(2, 1));
    repeat (5) tick();
    n_checks++; if (grant_cnt[2*16 +: 16] !== 16'd3) begin n_fail++; $display("FAIL stats_gcnt2 got %0d want 3", grant_cnt[2*16 +: 16]); end
    n_checks++; if (grant_cnt[0 +: 16] !== 16'd5) begin n_fail++; $display("FAIL stats_gcnt0 got %0d want 5", grant_cnt[0 +: 16]); end
    n_checks++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stats_stall got %0d want 5", stall_cnt); end
    req_d = '0;
    tick();
    soft_clear = 1'b1;
    tick();
    soft_clear = 1'b0;
    n_checks++; if (grant_cnt !== '0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_clear got gcnt=%h stall=%0d want 0", grant_cnt, stall_cnt); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin_full();
    test_hold();
    test_reset_mid();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
